// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives registered datapath enables and mux selects from the latched opcode.
module multicycle_control #(
    parameter int unsigned ALUOP_WIDTH = 3,
    parameter bit          WAIT_MEM    = 1'b1,
    parameter bit          ENABLE_JAL  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   PCWriteCondEQ,
    output logic                   PCWriteCondNE,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   MemtoReg,
    output logic [1:0]             RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   illegal_op,
    output logic [3:0]             state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StAluWbR  = 4'd7,
        StExecI   = 4'd8,
        StAluWbI  = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StJal     = 4'd12,
        StIllegal = 4'd13
    } state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       condEq;
        logic       condNe;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic [1:0] regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSource;
        logic [2:0] aluOp;
        logic       illegal;
    } ctrl_t;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluLui   = 3'b011;
    localparam logic [2:0] AluAddi  = 3'b100;
    localparam logic [2:0] AluOri   = 3'b101;
    localparam logic [2:0] AluAndi  = 3'b110;
    localparam logic [2:0] AluRtype = 3'b111;

    function automatic ctrl_t decodeCtrl(input state_t st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.memRead = 1'b1;
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
                c.aluSrcB = 2'd1;
                c.aluOp   = AluAdd;
            end
            StDecode: begin
                c.aluSrcB = 2'd3;
                c.aluOp   = AluAdd;
            end
            StMemAdr: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'd2;
                c.aluOp   = AluAdd;
            end
            StMemRd: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            StMemWb: begin
                c.regWrite = 1'b1;
                c.memtoReg = 1'b1;
            end
            StMemWr: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            StExecR: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = AluRtype;
            end
            StAluWbR: begin
                c.regWrite = 1'b1;
                c.regDst   = 2'd1;
            end
            StExecI: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'd2;
                case (op)
                    6'h0d:   c.aluOp = AluOri;
                    6'h0c:   c.aluOp = AluAndi;
                    6'h0f:   c.aluOp = AluLui;
                    default: c.aluOp = AluAddi;
                endcase
            end
            StAluWbI: c.regWrite = 1'b1;
            StBranch: begin
                c.aluSrcA  = 1'b1;
                c.aluOp    = AluSub;
                c.pcSource = 2'd1;
                c.condEq   = (op == 6'h04);
                c.condNe   = (op == 6'h05);
            end
            StJump: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'd2;
            end
            StJal: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'd2;
                c.regWrite = 1'b1;
                c.regDst   = 2'd2;
                c.aluOp    = AluAdd;
            end
            StIllegal: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t     stateQ, stateD;
    ctrl_t      ctrlQ, ctrlOut;
    logic [5:0] opQ, opSel;
    logic       memOk, outEn;

    assign memOk = !WAIT_MEM || mem_ready;
    // Opcode is live during DECODE and latched afterwards, so late IR changes are ignored.
    assign opSel = (stateQ == StDecode) ? OP : opQ;

    always_comb begin
        stateD = StFetch;
        case (stateQ)
            StFetch:  stateD = memOk ? StDecode : StFetch;
            StDecode: begin
                case (OP)
                    6'h00:                      stateD = StExecR;
                    6'h23, 6'h2b:               stateD = StMemAdr;
                    6'h04, 6'h05:               stateD = StBranch;
                    6'h08, 6'h0d, 6'h0c, 6'h0f: stateD = StExecI;
                    6'h02:                      stateD = StJump;
                    6'h03:                      stateD = ENABLE_JAL ? StJal : StIllegal;
                    default:                    stateD = StIllegal;
                endcase
            end
            StMemAdr: stateD = (opQ == 6'h23) ? StMemRd : StMemWr;
            StMemRd:  stateD = memOk ? StMemWb : StMemRd;
            StMemWr:  stateD = memOk ? StFetch : StMemWr;
            StExecR:  stateD = StAluWbR;
            StExecI:  stateD = StAluWbI;
            default:  stateD = StFetch;
        endcase
    end

    // Outputs are registered by decoding the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StFetch;
            ctrlQ  <= decodeCtrl(StFetch, 6'h00);
            opQ    <= 6'h00;
        end else begin
            stateQ <= stateD;
            ctrlQ  <= decodeCtrl(stateD, opSel);
            if (stateQ == StDecode) begin
                opQ <= OP;
            end
        end
    end

    assign outEn   = !reset && (stateQ <= StIllegal);
    assign ctrlOut = outEn ? ctrlQ : '0;

    // Fetch loads IR and PC only on the cycle the memory delivers the word.
    assign PCWrite       = ctrlOut.pcWrite && (memOk || !ctrlOut.irWrite);
    assign IRWrite       = ctrlOut.irWrite && memOk;
    assign PCWriteCondEQ = ctrlOut.condEq;
    assign PCWriteCondNE = ctrlOut.condNe;
    assign IorD          = ctrlOut.iorD;
    assign MemRead       = ctrlOut.memRead;
    assign MemWrite      = ctrlOut.memWrite;
    assign MemtoReg      = ctrlOut.memtoReg;
    assign RegDst        = ctrlOut.regDst;
    assign RegWrite      = ctrlOut.regWrite;
    assign ALUSrcA       = ctrlOut.aluSrcA;
    assign ALUSrcB       = ctrlOut.aluSrcB;
    assign PCSource      = ctrlOut.pcSource;
    assign ALUOp         = ALUOP_WIDTH'(ctrlOut.aluOp);
    assign illegal_op    = ctrlOut.illegal;
    assign state         = reset ? 4'd0 : stateQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: default, JAL-disabled and no-wait variants.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       memReady;
    logic [5:0] op;

    always #5 clk = ~clk;

    logic       pcw [3];
    logic       ceq [3];
    logic       cne [3];
    logic       iord[3];
    logic       mrd [3];
    logic       mwr [3];
    logic       irw [3];
    logic       m2r [3];
    logic [1:0] rdst[3];
    logic       rw  [3];
    logic       asa [3];
    logic [1:0] asb [3];
    logic [1:0] pcs [3];
    logic [2:0] aop [3];
    logic       ill [3];
    logic [3:0] obsSt [3];
    logic [19:0] obsVec [3];

    multicycle_control #(.ALUOP_WIDTH(3), .WAIT_MEM(1'b1), .ENABLE_JAL(1'b1)) dut (
        .clk(clk), .reset(reset), .OP(op), .mem_ready(memReady),
        .PCWrite(pcw[0]), .PCWriteCondEQ(ceq[0]), .PCWriteCondNE(cne[0]), .IorD(iord[0]),
        .MemRead(mrd[0]), .MemWrite(mwr[0]), .IRWrite(irw[0]), .MemtoReg(m2r[0]),
        .RegDst(rdst[0]), .RegWrite(rw[0]), .ALUSrcA(asa[0]), .ALUSrcB(asb[0]),
        .PCSource(pcs[0]), .ALUOp(aop[0]), .illegal_op(ill[0]), .state(obsSt[0])
    );

    multicycle_control #(.ALUOP_WIDTH(3), .WAIT_MEM(1'b1), .ENABLE_JAL(1'b0)) dutNoJal (
        .clk(clk), .reset(reset), .OP(op), .mem_ready(memReady),
        .PCWrite(pcw[1]), .PCWriteCondEQ(ceq[1]), .PCWriteCondNE(cne[1]), .IorD(iord[1]),
        .MemRead(mrd[1]), .MemWrite(mwr[1]), .IRWrite(irw[1]), .MemtoReg(m2r[1]),
        .RegDst(rdst[1]), .RegWrite(rw[1]), .ALUSrcA(asa[1]), .ALUSrcB(asb[1]),
        .PCSource(pcs[1]), .ALUOp(aop[1]), .illegal_op(ill[1]), .state(obsSt[1])
    );

    multicycle_control #(.ALUOP_WIDTH(3), .WAIT_MEM(1'b0), .ENABLE_JAL(1'b1)) dutNoWait (
        .clk(clk), .reset(reset), .OP(op), .mem_ready(1'b0),
        .PCWrite(pcw[2]), .PCWriteCondEQ(ceq[2]), .PCWriteCondNE(cne[2]), .IorD(iord[2]),
        .MemRead(mrd[2]), .MemWrite(mwr[2]), .IRWrite(irw[2]), .MemtoReg(m2r[2]),
        .RegDst(rdst[2]), .RegWrite(rw[2]), .ALUSrcA(asa[2]), .ALUSrcB(asb[2]),
        .PCSource(pcs[2]), .ALUOp(aop[2]), .illegal_op(ill[2]), .state(obsSt[2])
    );

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            obsVec[k] = {pcw[k], ceq[k], cne[k], iord[k], mrd[k], mwr[k], irw[k], m2r[k],
                         rdst[k], rw[k], asa[k], asb[k], pcs[k], aop[k], ill[k]};
        end
    end

    typedef struct {
        logic        rdy;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [19:0] vec;
    } entry_t;

    entry_t sb[$];
    int checks = 0;
    int failures = 0;

    // Expected control vector for a state, from the state table.
    function automatic logic [19:0] model(input logic [3:0] st, input logic [5:0] o,
                                          input logic rdy);
        logic pw, eq, ne, io, mr, mw, ir, mtr, wr, sa, il;
        logic [1:0] rd, sbv, ps;
        logic [2:0] ao;
        {pw, eq, ne, io, mr, mw, ir, mtr, wr, sa, il} = '0;
        rd = 2'd0; sbv = 2'd0; ps = 2'd0; ao = 3'd0;
        case (st)
            4'd0:  begin mr = 1'b1; sbv = 2'd1; pw = rdy; ir = rdy; end
            4'd1:  sbv = 2'd3;
            4'd2:  begin sa = 1'b1; sbv = 2'd2; end
            4'd3:  begin mr = 1'b1; io = 1'b1; end
            4'd4:  begin wr = 1'b1; mtr = 1'b1; end
            4'd5:  begin mw = 1'b1; io = 1'b1; end
            4'd6:  begin sa = 1'b1; ao = 3'b111; end
            4'd7:  begin wr = 1'b1; rd = 2'd1; end
            4'd8: begin
                sa = 1'b1; sbv = 2'd2;
                ao = (o == 6'h0d) ? 3'b101 : (o == 6'h0c) ? 3'b110 :
                     (o == 6'h0f) ? 3'b011 : 3'b100;
            end
            4'd9:  wr = 1'b1;
            4'd10: begin
                sa = 1'b1; ao = 3'b001; ps = 2'd1; eq = (o == 6'h04); ne = (o == 6'h05);
            end
            4'd11: begin pw = 1'b1; ps = 2'd2; end
            4'd12: begin pw = 1'b1; ps = 2'd2; wr = 1'b1; rd = 2'd2; end
            4'd13: il = 1'b1;
            default: ;
        endcase
        return {pw, eq, ne, io, mr, mw, ir, mtr, rd, wr, sa, sbv, ps, ao, il};
    endfunction

    task automatic push(input logic [3:0] st, input logic [5:0] drv, input logic [5:0] lat,
                        input logic rdy);
        entry_t e;
        e.rdy = rdy;
        e.op  = drv;
        e.st  = st;
        e.vec = model(st, lat, rdy);
        sb.push_back(e);
    endtask

    // Queue the expected per-cycle trace of one instruction; 'late' is driven after DECODE.
    task automatic plan(input logic [5:0] o, input logic [5:0] late, input int fw, input int mw,
                        input bit enJal);
        for (int i = 0; i < fw; i++) push(4'd0, o, o, 1'b0);
        push(4'd0, o, o, 1'b1);
        push(4'd1, o, o, 1'b1);
        case (o)
            6'h00: begin push(4'd6, late, o, 1'b1); push(4'd7, late, o, 1'b1); end
            6'h23: begin
                push(4'd2, late, o, 1'b1);
                for (int i = 0; i < mw; i++) push(4'd3, late, o, 1'b0);
                push(4'd3, late, o, 1'b1);
                push(4'd4, late, o, 1'b1);
            end
            6'h2b: begin
                push(4'd2, late, o, 1'b1);
                for (int i = 0; i < mw; i++) push(4'd5, late, o, 1'b0);
                push(4'd5, late, o, 1'b1);
            end
            6'h04, 6'h05: push(4'd10, late, o, 1'b1);
            6'h08, 6'h0d, 6'h0c, 6'h0f: begin
                push(4'd8, late, o, 1'b1); push(4'd9, late, o, 1'b1);
            end
            6'h02: push(4'd11, late, o, 1'b1);
            6'h03: push(enJal ? 4'd12 : 4'd13, late, o, 1'b1);
            default: push(4'd13, late, o, 1'b1);
        endcase
    endtask

    // Pop each expected cycle, drive its inputs and compare the selected DUT.
    task automatic scoreboard_drain(input int sel, output int cycles, output int irCount);
        entry_t e;
        cycles  = 0;
        irCount = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            op       = e.op;
            memReady = e.rdy;
            #1;
            checks++;
            if (obsSt[sel] !== e.st) begin
                failures++;
                $display("FAIL state dut=%0d cyc=%0d got=%0d exp=%0d", sel, cycles, obsSt[sel],
                         e.st);
            end
            checks++;
            if (obsVec[sel] !== e.vec) begin
                failures++;
                $display("FAIL ctrl dut=%0d cyc=%0d st=%0d got=%b exp=%b", sel, cycles, e.st,
                         obsVec[sel], e.vec);
            end
            if (irw[sel] === 1'b1) irCount++;
            cycles++;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset    = 1'b1;
        memReady = 1'b1;
        op       = 6'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset    = 1'b1;
        memReady = 1'b1;
        op       = 6'h23;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obsSt[0] !== 4'd0 || obsVec[0] !== 20'd0) begin
                failures++;
                $display("FAIL reset_outputs got st=%0d vec=%b exp st=0 vec=0", obsSt[0],
                         obsVec[0]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic checkFetch(input int sel, input string name);
        @(negedge clk);
        #1;
        checks++;
        if (obsSt[sel] !== 4'd0) begin
            failures++;
            $display("FAIL %s_return got st=%0d exp 0", name, obsSt[sel]);
        end
    endtask

    task automatic test_rtype();
        int cyc, irc;
        applyReset();
        plan(6'h00, 6'h00, 0, 0, 1'b1);
        scoreboard_drain(0, cyc, irc);
        checks++;
        if (cyc != 4) begin
            failures++;
            $display("FAIL rtype_latency got=%0d exp=4", cyc);
        end
        checkFetch(0, "rtype");
    endtask

    task automatic test_lw_wait();
        int cyc, irc;
        applyReset();
        plan(6'h23, 6'h23, 2, 3, 1'b1);
        scoreboard_drain(0, cyc, irc);
        checks++;
        if (cyc != 10 || irc != 1) begin
            failures++;
            $display("FAIL lw_wait got cycles=%0d irwrite=%0d exp cycles=10 irwrite=1", cyc, irc);
        end
        checkFetch(0, "lw");
    endtask

    task automatic test_back_to_back_sw_bne();
        int cyc, irc;
        applyReset();
        plan(6'h2b, 6'h2b, 1, 2, 1'b1);
        plan(6'h05, 6'h05, 0, 0, 1'b1);
        plan(6'h04, 6'h04, 0, 0, 1'b1);
        scoreboard_drain(0, cyc, irc);
        checks++;
        if (cyc != 13 || irc != 3) begin
            failures++;
            $display("FAIL sw_bne_seq got cycles=%0d irwrite=%0d exp 13/3", cyc, irc);
        end
        checkFetch(0, "branch");
    endtask

    task automatic test_itype();
        int cyc, irc;
        applyReset();
        plan(6'h0d, 6'h0d, 0, 0, 1'b1);
        plan(6'h0c, 6'h3f, 0, 0, 1'b1);
        plan(6'h0f, 6'h0f, 0, 0, 1'b1);
        plan(6'h08, 6'h00, 0, 0, 1'b1);
        plan(6'h02, 6'h02, 0, 0, 1'b1);
        scoreboard_drain(0, cyc, irc);
        checks++;
        if (cyc != 19) begin
            failures++;
            $display("FAIL itype_seq got cycles=%0d exp=19", cyc);
        end
        checkFetch(0, "itype");
    endtask

    task automatic test_jal_illegal();
        int cyc, irc;
        applyReset();
        plan(6'h03, 6'h03, 0, 0, 1'b1);
        scoreboard_drain(0, cyc, irc);
        checks++;
        if (cyc != 3) begin
            failures++;
            $display("FAIL jal_latency got=%0d exp=3", cyc);
        end
        applyReset();
        plan(6'h03, 6'h03, 0, 0, 1'b0);
        plan(6'h3f, 6'h3f, 0, 0, 1'b0);
        scoreboard_drain(1, cyc, irc);
        checks++;
        if (cyc != 6) begin
            failures++;
            $display("FAIL illegal_latency got=%0d exp=6", cyc);
        end
        checkFetch(1, "illegal");
    endtask

    task automatic test_reset_abort();
        applyReset();
        op = 6'h23;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            memReady = 1'b1;
        end
        @(negedge clk);
        memReady = 1'b0;
        #1;
        checks++;
        if (obsSt[0] !== 4'd3 || mrd[0] !== 1'b1 || iord[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_memrd got st=%0d rd=%b iord=%b exp st=3 1 1", obsSt[0],
                     mrd[0], iord[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (obsSt[0] !== 4'd0 || obsVec[0] !== 20'd0) begin
            failures++;
            $display("FAIL abort_reset got st=%0d vec=%b exp st=0 vec=0", obsSt[0], obsVec[0]);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        memReady = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (obsSt[0] !== 4'd0 || obsVec[0] !== model(4'd0, 6'h00, 1'b1)) begin
            failures++;
            $display("FAIL abort_fetch got st=%0d vec=%b exp st=0 vec=%b", obsSt[0], obsVec[0],
                     model(4'd0, 6'h00, 1'b1));
        end
    endtask

    task automatic test_no_wait();
        int cyc, irc;
        applyReset();
        plan(6'h23, 6'h23, 0, 0, 1'b1);
        plan(6'h2b, 6'h2b, 0, 0, 1'b1);
        scoreboard_drain(2, cyc, irc);
        checks++;
        if (cyc != 9 || irc != 2) begin
            failures++;
            $display("FAIL nowait_lw_sw got cycles=%0d irwrite=%0d exp 9/2", cyc, irc);
        end
        checkFetch(2, "nowait");
    endtask

    initial begin
        reset    = 1'b1;
        memReady = 1'b0;
        op       = 6'h00;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back_sw_bne();
        test_itype();
        test_jal_illegal();
        test_reset_abort();
        test_no_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
